// File: rtl/debug_pkg.sv
// Shared types and constants for the debug result return path
// (frame FSM encoding, UART frame geometry, debug size codes).
package debug_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int unsigned FRAME_BITS    = 10;
  localparam int unsigned DATA_BITS     = 8;
  localparam int unsigned NUM_BYTES_MAX = 4;

  typedef enum logic [1:0] {
    SIZE_1B = 2'd0,
    SIZE_2B = 2'd1,
    SIZE_3B = 2'd2,
    SIZE_4B = 2'd3
  } size_e;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 transmitter; a tx_start seen as the stop bit completes
// launches the next start bit on the same edge, so bytes chain with no gap.
module uart_tx_byte
  import debug_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int unsigned TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      data_q, data_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            wrap_c;

  assign wrap_c = (timer_q == T_LAST);

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        timer_d = '0;
        if (tx_start) begin
          state_d = START;
          data_d  = tx_data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        timer_d = timer_q + TW'(1);
        if (wrap_c) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          tx_d      = data_q[0];
        end
      end
      DATA: begin
        timer_d = timer_q + TW'(1);
        if (wrap_c) begin
          timer_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            data_d    = data_q >> 1;
            tx_d      = data_q[1];
          end
        end
      end
      STOP: begin
        timer_d = timer_q + TW'(1);
        if (wrap_c) begin
          timer_d = '0;
          done_d  = 1'b1;
          if (tx_start) begin
            state_d = START;
            data_d  = tx_data;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: rtl/debug_result_serializer.sv
// Ships the decoder's result back to the host as (size+1) UART bytes,
// least-significant byte first, with stop and next start bit abutting.
module debug_result_serializer
  import debug_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] result,
  input  logic [1:0]  size,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int unsigned SHW = DATA_BITS * (NUM_BYTES_MAX - 1);

  logic [SHW-1:0] shift_q, shift_d;
  logic [2:0]     bytes_left_q, bytes_left_d;
  logic           accept_c;
  logic           tx_start_c;
  logic [7:0]     tx_data_c;
  logic           tx_busy;
  logic           tx_done;

  // Byte 0 goes straight from the input; later bytes come from the shifter,
  // which is advanced one cycle after each byte's stop bit (already latched).
  assign accept_c   = start && !tx_busy;
  assign tx_start_c = tx_busy ? (bytes_left_q > 3'd1) : start;
  assign tx_data_c  = tx_busy ? shift_q[7:0] : result[7:0];

  always_comb begin
    shift_d      = shift_q;
    bytes_left_d = bytes_left_q;
    if (accept_c) begin
      shift_d      = result[31:DATA_BITS];
      bytes_left_d = 3'(size) + 3'd1;
    end else if (tx_done && (bytes_left_q != 3'd0)) begin
      shift_d      = shift_q >> DATA_BITS;
      bytes_left_d = bytes_left_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q      <= '0;
      bytes_left_q <= '0;
    end else begin
      shift_q      <= shift_d;
      bytes_left_q <= bytes_left_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .tx_start(tx_start_c),
    .tx_data (tx_data_c),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx      (tx)
  );

  assign busy = tx_busy;
  assign done = tx_done && (bytes_left_q == 3'd1);

endmodule
